// File: rtl/fun_sweep_if.sv
// Handshake and data bundle between a sweep requester and fun_sweep_ctrl.
// The controller sits on the slave side.
interface fun_sweep_if;
  logic        start;
  logic        abort;
  logic [4:0]  lo;
  logic [4:0]  hi;
  logic        f;
  logic        a;
  logic        b;
  logic        c;
  logic        d;
  logic        e;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] result;
  logic [5:0]  ones;

  modport master (
    output start,
    output abort,
    output lo,
    output hi,
    output f,
    input  a,
    input  b,
    input  c,
    input  d,
    input  e,
    input  busy,
    input  done,
    input  err,
    input  result,
    input  ones
  );

  modport slave (
    input  start,
    input  abort,
    input  lo,
    input  hi,
    input  f,
    output a,
    output b,
    output c,
    output d,
    output e,
    output busy,
    output done,
    output err,
    output result,
    output ones
  );
endinterface

// File: rtl/fun_sweep_ctrl.sv
// Sweeps a 5-bit operand range through a shared function unit,
// collecting one sampled output bit per vector plus a ones count.
module fun_sweep_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  fun_sweep_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t      state_q, state_d;
  logic [4:0]  cur_q, cur_d;
  logic [4:0]  hi_q, hi_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] result_q, result_d;
  logic [5:0]  ones_q, ones_d;
  logic        err_q, err_d;
  logic        active;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cur_q    <= '0;
      hi_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ones_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      hi_q     <= hi_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ones_q   <= ones_d;
      err_q    <= err_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    hi_d     = hi_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ones_d   = ones_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          result_d = '0;
          ones_d   = '0;
          if (bus.lo > bus.hi) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            cur_d   = bus.lo;
            hi_d    = bus.hi;
            cnt_d   = '0;
            state_d = DRIVE;
          end
        end
      end
      DRIVE: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      SAMPLE: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          result_d[cur_q] = bus.f;
          ones_d = ones_q + {5'b0, bus.f};
          // End on equality only, so hi=31 never wraps
          if (cur_q == hi_q) begin
            state_d = DONE;
          end else begin
            cur_d   = cur_q + 5'd1;
            cnt_d   = '0;
            state_d = DRIVE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from state and registers only
  always_comb begin
    active = (state_q == DRIVE) || (state_q == SAMPLE);
    bus.busy   = active;
    bus.done   = (state_q == DONE);
    bus.err    = err_q;
    bus.result = result_q;
    bus.ones   = ones_q;
    {bus.a, bus.b, bus.c, bus.d, bus.e} = active ? cur_q : 5'b0;
  end

endmodule

// File: tb/tb_fun_sweep_ctrl.sv
// Directed bench for fun_sweep_ctrl with a parity function stub.
// Unit A runs SETTLE=1 scenarios, unit B runs SETTLE=3.
module tb_fun_sweep_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   n;
  int   m;

  always #5 clk = ~clk;

  fun_sweep_if ia();
  fun_sweep_if ib();

  assign ia.f = ia.a ^ ia.b ^ ia.c ^ ia.d ^ ia.e;
  assign ib.f = ib.a ^ ib.b ^ ib.c ^ ib.d ^ ib.e;

  fun_sweep_ctrl #(.SETTLE(1)) u_a (
    .clk(clk),
    .rst_n(rst_n),
    .bus(ia.slave)
  );

  fun_sweep_ctrl #(.SETTLE(3)) u_b (
    .clk(clk),
    .rst_n(rst_n),
    .bus(ib.slave)
  );

  function automatic logic [4:0] va();
    return {ia.a, ia.b, ia.c, ia.d, ia.e};
  endfunction

  function automatic logic [4:0] vb();
    return {ib.a, ib.b, ib.c, ib.d, ib.e};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_a(output int cyc);
    cyc = 0;
    while (ia.busy === 1'b1 && cyc < 200) begin
      cyc++;
      tick();
    end
  endtask

  task automatic sweep_a(input logic [4:0] lo,
                         input logic [4:0] hi);
    ia.lo = lo;
    ia.hi = hi;
    ia.start = 1'b1;
    tick();
    ia.start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    ia.start = 1'b0;
    ia.abort = 1'b0;
    ia.lo = '0;
    ia.hi = '0;
    ib.start = 1'b0;
    ib.abort = 1'b0;
    ib.lo = '0;
    ib.hi = '0;

    #2;
    chk("rst_busy", 32'(ia.busy), 32'd0);
    chk("rst_done", 32'(ia.done), 32'd0);
    chk("rst_err", 32'(ia.err), 32'd0);
    chk("rst_result", ia.result, 32'd0);
    chk("rst_ones", 32'(ia.ones), 32'd0);
    chk("rst_vec", 32'(va()), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    sweep_a(5'd0, 5'd3);
    chk("t1_busy", 32'(ia.busy), 32'd1);
    chk("t1_vec0", 32'(va()), 32'd0);
    run_a(n);
    chk("t1_cycles", 32'(n), 32'd8);
    chk("t1_done", 32'(ia.done), 32'd1);
    chk("t1_err", 32'(ia.err), 32'd0);
    chk("t1_result", ia.result, 32'h0000_0006);
    chk("t1_ones", 32'(ia.ones), 32'd2);
    tick();
    chk("t1_done_low", 32'(ia.done), 32'd0);

    sweep_a(5'd0, 5'd31);
    run_a(n);
    chk("t2_cycles", 32'(n), 32'd64);
    chk("t2_done", 32'(ia.done), 32'd1);
    chk("t2_result", ia.result, 32'h9669_6996);
    chk("t2_ones", 32'(ia.ones), 32'd16);
    ia.start = 1'b1;
    ia.lo = 5'd0;
    ia.hi = 5'd0;
    tick();
    ia.start = 1'b0;
    chk("t2_start_in_done", 32'(ia.busy), 32'd0);
    chk("t2_vec_idle", 32'(va()), 32'd0);
    tick();
    chk("t2_no_wrap", 32'(ia.busy), 32'd0);
    chk("t2_hold", ia.result, 32'h9669_6996);
    chk("t2_hold_ones", 32'(ia.ones), 32'd16);

    sweep_a(5'd5, 5'd2);
    chk("t3_done", 32'(ia.done), 32'd1);
    chk("t3_err", 32'(ia.err), 32'd1);
    chk("t3_busy", 32'(ia.busy), 32'd0);
    chk("t3_result", ia.result, 32'd0);
    chk("t3_ones", 32'(ia.ones), 32'd0);
    tick();
    chk("t3_done_low", 32'(ia.done), 32'd0);
    chk("t3_err_hold", 32'(ia.err), 32'd1);
    chk("t3_busy_low", 32'(ia.busy), 32'd0);

    sweep_a(5'd0, 5'd31);
    chk("t4_err_clr", 32'(ia.err), 32'd0);
    repeat (8) tick();
    chk("t4_vec4", 32'(va()), 32'd4);
    chk("t4_busy", 32'(ia.busy), 32'd1);
    ia.abort = 1'b1;
    tick();
    chk("t4_busy_low", 32'(ia.busy), 32'd0);
    chk("t4_no_done", 32'(ia.done), 32'd0);
    chk("t4_result", ia.result, 32'h0000_0006);
    chk("t4_ones", 32'(ia.ones), 32'd2);
    tick();
    ia.abort = 1'b0;
    chk("t4_idle_abort", 32'(ia.done), 32'd0);
    chk("t4_result_hold", ia.result, 32'h0000_0006);

    sweep_a(5'd0, 5'd31);
    repeat (10) tick();
    chk("t5_busy", 32'(ia.busy), 32'd1);
    chk("t5_partial", ia.result, 32'h0000_0016);
    rst_n = 1'b0;
    #1;
    chk("t5_busy_rst", 32'(ia.busy), 32'd0);
    chk("t5_vec_rst", 32'(va()), 32'd0);
    chk("t5_result_rst", ia.result, 32'd0);
    chk("t5_ones_rst", 32'(ia.ones), 32'd0);
    chk("t5_done_rst", 32'(ia.done), 32'd0);
    #3;
    rst_n = 1'b1;
    tick();
    sweep_a(5'd0, 5'd3);
    run_a(n);
    chk("t5_cycles", 32'(n), 32'd8);
    chk("t5_done", 32'(ia.done), 32'd1);
    chk("t5_result", ia.result, 32'h0000_0006);
    chk("t5_ones", 32'(ia.ones), 32'd2);

    ib.lo = 5'd7;
    ib.hi = 5'd7;
    ib.start = 1'b1;
    tick();
    n = 0;
    m = 0;
    while (ib.busy === 1'b1 && n < 200) begin
      n++;
      if (vb() == 5'd7) m++;
      tick();
    end
    ib.start = 1'b0;
    chk("t6_cycles", 32'(n), 32'd4);
    chk("t6_vec_cycles", 32'(m), 32'd4);
    chk("t6_done", 32'(ib.done), 32'd1);
    chk("t6_result", ib.result, 32'h0000_0080);
    chk("t6_ones", 32'(ib.ones), 32'd1);
    chk("t6_err", 32'(ib.err), 32'd0);
    tick();
    chk("t6_busy_low", 32'(ib.busy), 32'd0);
    chk("t6_done_low", 32'(ib.done), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fun_sweep_ctrl.md
FUN_SWEEP_CTRL -- requirements
Module: fun_sweep_ctrl

Interface
REQ-001 Parameter: SETTLE, default 1, number of cycles each vector is driven before f is sampled; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  sweep request; sampled only in IDLE.
REQ-005 abort  input  1  terminates an active sweep.
REQ-006 lo  input  5  first vector {a,b,c,d,e} of the sweep; latched on accepted start.
REQ-007 hi  input  5  last vector of the sweep; latched on accepted start.
REQ-008 f  input  1  output of the shared combinational function unit under control.
REQ-009 a, b, c, d, e  output  1 each  operand bits driven to the function unit; a is MSB of the vector.
REQ-010 busy  output  1  high while in DRIVE or SAMPLE.
REQ-011 done  output  1  one-cycle pulse at sweep end, including error end.
REQ-012 err  output  1  set when start is accepted with lo > hi.
REQ-013 result  output  32  bit i holds f sampled for vector i.
REQ-014 ones  output  6  count of f=1 samples in the current sweep, 0..32.

Function
REQ-015 States: IDLE, DRIVE, SAMPLE, DONE.
REQ-016 IDLE with start=1 and lo<=hi: latch lo and hi, set cur=lo, clear result, ones and err, then go to DRIVE.
REQ-017 IDLE with start=1 and lo>hi: set err=1, clear result and ones, then go to DONE; busy stays 0.
REQ-018 DRIVE: {a,b,c,d,e}=cur; remain for exactly SETTLE cycles, then go to SAMPLE.
REQ-019 SAMPLE, one cycle: {a,b,c,d,e}=cur; result[cur]<=f; ones<=ones+f.
REQ-020 SAMPLE exit: if cur==hi go to DONE, else cur<=cur+1 and go to DRIVE.
REQ-021 Termination is by equality with hi only; cur never wraps; hi=31 ends after vector 31.
REQ-022 Per-vector cost is SETTLE+1 cycles; an N-vector sweep holds busy high for N*(SETTLE+1) cycles.
REQ-023 DONE, one cycle: done=1, then go to IDLE.
REQ-024 In IDLE and DONE, {a,b,c,d,e}=5'b00000.
REQ-025 start is ignored outside IDLE, including in the DONE cycle.
REQ-026 abort in DRIVE or SAMPLE: go to IDLE on the next edge; no done pulse; result and ones keep their partial values; a SAMPLE cycle coincident with abort does not update result or ones.
REQ-027 abort in IDLE or DONE has no effect.
REQ-028 result, ones and err hold their values after DONE until the next accepted start.
REQ-029 All outputs are registered or decoded from state/cur only; there is no combinational path from f to any output.

Reset
REQ-030 rst_n=0, asserted at any time including mid-sweep, immediately forces IDLE, cur=0, {a,b,c,d,e}=0, busy=0, done=0, err=0, result=0, ones=0.
REQ-031 After rst_n deasserts, the first start is accepted on the first rising edge on which it is sampled high.

Verification
Bench stub for all scenarios: f = a^b^c^d^e.
REQ-032 SETTLE=1, lo=0, hi=3, start pulse -> busy high 8 cycles; done on cycle 9; result=32'h0000_0006; ones=2; err=0.
REQ-033 SETTLE=1, lo=0, hi=31 -> busy 64 cycles; result=32'h9669_6996; ones=16; no wrap to vector 0 after 31.
REQ-034 lo=5, hi=2, start -> err=1 and done pulse on the cycle after start; busy never high; result=0; ones=0.
REQ-035 SETTLE=3, lo=hi=7 -> vector 00111 driven for 4 cycles; result=32'h0000_0080; ones=1; start held high during the sweep has no effect.
REQ-036 Full sweep with abort asserted during vector 4's DRIVE -> IDLE next edge; no done; result=32'h0000_0006; ones=2.
REQ-037 Full sweep with rst_n pulsed low mid-sweep -> all outputs 0 asynchronously; a new sweep then runs normally.
